sample_capture_controller: RTL

- Hardware sequencer that drains the sampler's negedge/posedge FIFOs into sample_ram without per-word MPU port traffic.
- Arbitrates round-robin between the two FIFOs and discards samples until a masked trigger pattern matches.
- After the trigger, writes a programmed number of 32-bit words to consecutive RAM addresses from 0, then reports done.
- The MPU drives start, stop and the configuration inputs through its port registers, and reads status and word_count.

---
 rtl/sample_capture_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sample_capture_controller.sv
`default_nettype none
// ============================================================================
// Module      : sample_capture_controller
// Description : Drains the sampler's negedge/posedge FIFOs into sample_ram.
//               Round-robin FIFO arbitration, masked trigger detection, and
//               a programmable number of stored words after the trigger.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_capture_controller #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH-1:0] capture_length,
    input  logic [DATA_WIDTH-1:0] trigger_mask,
    input  logic [DATA_WIDTH-1:0] trigger_value,
    input  logic                  negedge_empty,
    input  logic                  posedge_empty,
    input  logic                  negedge_full,
    input  logic                  posedge_full,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  negedge_read_enable,
    output logic                  posedge_read_enable,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // A programmed length of 0 stands for the whole address space.
    localparam logic [ADDR_WIDTH:0]   c_full_length = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   c_count_one   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_addr_one    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t r_state;
    logic   r_last_posedge;   // 1: posedge FIFO was served last
    logic   r_d_valid;        // fifo_data holds a freshly popped word this cycle
    logic   r_stop_req;       // stop seen, waiting for the pipeline to drain
    logic   r_final;          // the word now heading to RAM closes the capture

    logic                w_read_active;
    logic                w_match;
    logic                w_store;
    logic                w_stop;
    logic                w_last_word;
    logic                w_issue;
    logic                w_pick_posedge;
    logic                w_start_ok;
    logic                w_finish;
    logic [ADDR_WIDTH:0] w_eff_length;

    assign w_eff_length   = (capture_length == '0) ? c_full_length : {1'b0, capture_length};
    assign w_read_active  = negedge_read_enable | posedge_read_enable;
    assign w_match        = ((fifo_data ^ trigger_value) & trigger_mask) == '0;
    // Stage D: a captured word is stored in CAPTURE, or in ARMED when it triggers.
    assign w_store        = r_d_valid & ((r_state == S_CAPTURE) | ((r_state == S_ARMED) & w_match));
    assign w_stop         = stop | r_stop_req;
    assign w_last_word    = (word_count + c_count_one) == w_eff_length;
    // Prefer the FIFO not served last when both hold data.
    assign w_pick_posedge = posedge_empty ? 1'b0 : (negedge_empty ? 1'b1 : ~r_last_posedge);
    // One read in flight at most; no read once the final word is known.
    assign w_issue        = busy & ~w_stop & ~w_read_active & ~r_final
                          & ~(w_store & w_last_word)
                          & (~negedge_empty | ~posedge_empty);
    assign w_start_ok     = start & ~stop & ~busy;
    // Leave the busy states once the closing write retires, or on stop with
    // nothing left that still has to reach the RAM.
    assign w_finish       = (ram_wren & r_final) | (w_stop & ~w_read_active & ~w_store);

    // Capture sequencer: read issue, trigger evaluation, RAM write and state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state             <= S_IDLE;
            r_last_posedge      <= 1'b1;
            r_d_valid           <= 1'b0;
            r_stop_req          <= 1'b0;
            r_final             <= 1'b0;
            negedge_read_enable <= 1'b0;
            posedge_read_enable <= 1'b0;
            ram_address         <= '0;
            ram_data            <= '0;
            ram_wren            <= 1'b0;
            busy                <= 1'b0;
            triggered           <= 1'b0;
            done                <= 1'b0;
            overflow            <= 1'b0;
            word_count          <= '0;
        end else begin
            negedge_read_enable <= w_issue & ~w_pick_posedge;
            posedge_read_enable <= w_issue & w_pick_posedge;
            if (w_issue) begin
                r_last_posedge <= w_pick_posedge;
            end
            r_d_valid <= w_read_active;

            ram_wren <= w_store;
            if (w_store) begin
                ram_data <= fifo_data;
            end
            if (ram_wren) begin
                ram_address <= ram_address + c_addr_one;
                word_count  <= word_count + c_count_one;
            end

            if (busy && (negedge_full || posedge_full)) begin
                overflow <= 1'b1;
            end
            if (busy && stop) begin
                r_stop_req <= 1'b1;
            end
            if (w_store && (w_last_word || w_stop)) begin
                r_final <= 1'b1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_state     <= S_ARMED;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        ram_address <= '0;
                        word_count  <= '0;
                        triggered   <= 1'b0;
                        overflow    <= 1'b0;
                        r_stop_req  <= 1'b0;
                        r_final     <= 1'b0;
                    end
                end
                S_ARMED, S_CAPTURE: begin
                    if ((r_state == S_ARMED) && w_store) begin
                        r_state   <= S_CAPTURE;
                        triggered <= 1'b1;
                    end
                    if (w_finish) begin
                        r_state    <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        r_stop_req <= 1'b0;
                        r_final    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
